// File: rtl/sevenseg_scan_if.sv
// Display-driver bus for sevenseg_scan: load-side data/strobe plus the
// scanned display outputs. The optional brightness input exists only when
// SEVENSEG_DIMMING_EN is defined.
interface sevenseg_scan_if;
    logic [31:0] digits_in;
    logic [7:0]  dp_in;
    logic [7:0]  blank_in;
    logic        load;
    logic        busy;
    logic [7:0]  anode;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;
`ifdef SEVENSEG_DIMMING_EN
    logic [3:0]  brightness;
`endif

    // Side that supplies digit data (the user logic / testbench).
    modport master (
`ifdef SEVENSEG_DIMMING_EN
        output brightness,
`endif
        output digits_in, dp_in, blank_in, load,
        input  busy, anode, seg, dp, frame_tick
    );

    // The display driver itself.
    modport slave (
`ifdef SEVENSEG_DIMMING_EN
        input  brightness,
`endif
        input  digits_in, dp_in, blank_in, load,
        output busy, anode, seg, dp, frame_tick
    );
endinterface

// File: rtl/sevenseg_scan.sv
// sevenseg_scan: 8-digit multiplexed common-anode seven-segment driver.
// New digit data is captured into a staging buffer on load and copied to
// the display buffer only at a frame boundary (digit 7 -> 0), so a frame
// never shows a mix of old and new data.
// Optional feature macro: SEVENSEG_DIMMING_EN (PWM brightness on the anodes).
module sevenseg_scan #(
    parameter int unsigned CLK_FREQUENCY_HZ       = 100000000,
    parameter int unsigned DIGIT_FREQUENCY_HZ     = 1000,
    parameter int unsigned CNTR_WIDTH             = 32,
    parameter int unsigned SIMULATE               = 0,
    parameter int unsigned SIMULATE_FREQUENCY_CNT = 5
) (
    input  logic           clk,
    input  logic           reset,
    sevenseg_scan_if.slave bus
);

    localparam logic [CNTR_WIDTH-1:0] TOP_CNT = (SIMULATE != 0)
        ? CNTR_WIDTH'(SIMULATE_FREQUENCY_CNT)
        : CNTR_WIDTH'(CLK_FREQUENCY_HZ / DIGIT_FREQUENCY_HZ - 1);

    typedef struct packed {
        logic [31:0] digits;
        logic [7:0]  dp;
        logic [7:0]  blank;
    } frame_t;

    localparam frame_t FRAME_RESET = '{digits: 32'h0, dp: 8'h00, blank: 8'hFF};

    logic [CNTR_WIDTH-1:0] cnt;
    logic [2:0]            idx;
    logic                  step;
    logic                  boundary;
    frame_t                stage;
    frame_t                disp;
    frame_t                incoming;
    logic                  busy_q;
    logic                  tick_q;
    logic [7:0]            anode_q, nxt_anode;
    logic [6:0]            seg_q, nxt_seg;
    logic                  dp_q, nxt_dp;
    logic                  lit;

    assign step     = (cnt == TOP_CNT);
    assign boundary = step && (idx == 3'd7);
    assign incoming = '{digits: bus.digits_in, dp: bus.dp_in, blank: bus.blank_in};

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    // Dwell counter, digit index and frame-start pulse.
    // NOTE: registers use <= so every flop samples pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt    <= '0;
            idx    <= 3'd0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= boundary;
            if (step) begin
                cnt <= '0;
                idx <= idx + 3'd1;
            end else begin
                cnt <= cnt + CNTR_WIDTH'(1);
            end
        end
    end

    // Double buffer: load fills staging, a boundary commits it to the display.
    // NOTE: the buffers are reset on purpose so the display starts fully blank.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stage  <= FRAME_RESET;
            disp   <= FRAME_RESET;
            busy_q <= 1'b0;
        end else if (bus.load && boundary) begin
            stage  <= incoming;
            disp   <= incoming;
            busy_q <= 1'b0;
        end else if (bus.load) begin
            stage  <= incoming;
            busy_q <= 1'b1;
        end else if (boundary && busy_q) begin
            disp   <= stage;
            busy_q <= 1'b0;
        end
    end

`ifdef SEVENSEG_DIMMING_EN
    logic [3:0] pwm_cnt;

    // Free-running PWM phase; brightness is compared live, not staged.
    always_ff @(posedge clk) begin
        if (!reset) pwm_cnt <= 4'd0;
        else        pwm_cnt <= pwm_cnt + 4'd1;
    end

    assign lit = (pwm_cnt <= bus.brightness);
`else
    assign lit = 1'b1;
`endif

    // Decode the current digit of the display buffer into drive levels.
    // NOTE: defaults first so no path leaves an output unassigned (no latch).
    always_comb begin
        nxt_anode = 8'hFF;
        nxt_seg   = 7'h7F;
        nxt_dp    = 1'b1;
        if (!disp.blank[idx]) begin
            nxt_seg = hex_to_seg(disp.digits[{idx, 2'b00} +: 4]);
            nxt_dp  = ~disp.dp[idx];
            if (lit) nxt_anode = ~(8'd1 << idx);
        end
    end

    // Register the pin drivers so the display sees glitch-free levels.
    always_ff @(posedge clk) begin
        if (!reset) begin
            anode_q <= 8'hFF;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            anode_q <= nxt_anode;
            seg_q   <= nxt_seg;
            dp_q    <= nxt_dp;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.frame_tick = tick_q;
    assign bus.anode      = anode_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Self-checking bench for sevenseg_scan (SIMULATE=1, dwell 6, frame 48).
// The reference model derives the scan position from the number of clock
// edges since reset and keeps the staged/displayed data as plain records.
module tb_sevenseg_scan;

    localparam int DWELL = 6;
    localparam int FRAME = 8 * DWELL;

    typedef struct {
        logic [31:0] digits;
        logic [7:0]  dp;
        logic [7:0]  blank;
    } rec_t;

    logic clk = 1'b0;
    logic reset;
    sevenseg_scan_if intf ();

    sevenseg_scan #(
        .CLK_FREQUENCY_HZ      (100000000),
        .DIGIT_FREQUENCY_HZ    (1000),
        .CNTR_WIDTH            (32),
        .SIMULATE              (1),
        .SIMULATE_FREQUENCY_CNT(5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (intf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int         k;          // edges since reset release
    rec_t       m_disp, m_stage;
    logic       m_busy;
    logic [7:0] e_anode;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_tick;

    logic [6:0] seg_lut [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic rec_t blank_rec();
        rec_t r;
        r.digits = 32'h0;
        r.dp     = 8'h00;
        r.blank  = 8'hFF;
        return r;
    endfunction

    function automatic rec_t rand_rec();
        rec_t r;
        r.digits = $urandom;
        r.dp     = 8'($urandom);
        r.blank  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
        return r;
    endfunction

    function automatic rec_t mk(input logic [31:0] d, input logic [7:0] p, input logic [7:0] b);
        rec_t r;
        r.digits = d;
        r.dp     = p;
        r.blank  = b;
        return r;
    endfunction

    // What the pins should show for digit position pos of record r.
    task automatic expect_pins(input rec_t r, input int pos);
        int h;
        if (r.blank[pos]) begin
            e_anode = 8'hFF;
            e_seg   = 7'h7F;
            e_dp    = 1'b1;
        end else begin
            h       = (r.digits >> (4 * pos)) & 32'hF;
            e_anode = 8'hFF ^ (8'h01 << pos);
            e_seg   = seg_lut[h];
            e_dp    = r.dp[pos] ? 1'b0 : 1'b1;
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, compare.
    task automatic step(input logic rst_v, input logic ld, input rec_t f);
        logic bnd;
        reset          = rst_v;
        intf.load      = ld;
        intf.digits_in = f.digits;
        intf.dp_in     = f.dp;
        intf.blank_in  = f.blank;
        @(posedge clk);
        if (!rst_v) begin
            k       = 0;
            m_disp  = blank_rec();
            m_stage = blank_rec();
            m_busy  = 1'b0;
            e_anode = 8'hFF;
            e_seg   = 7'h7F;
            e_dp    = 1'b1;
            e_tick  = 1'b0;
        end else begin
            bnd = ((k % FRAME) == FRAME - 1);
            expect_pins(m_disp, (k / DWELL) % 8);
            e_tick = bnd;
            if (ld && bnd) begin
                m_disp  = f;
                m_stage = f;
                m_busy  = 1'b0;
            end else if (ld) begin
                m_stage = f;
                m_busy  = 1'b1;
            end else if (bnd && m_busy) begin
                m_disp = m_stage;
                m_busy = 1'b0;
            end
            k++;
        end
        #1;
        check("anode",      32'(intf.anode),      32'(e_anode));
        check("seg",        32'(intf.seg),        32'(e_seg));
        check("dp",         32'(intf.dp),         32'(e_dp));
        check("busy",       32'(intf.busy),       32'(m_busy));
        check("frame_tick", 32'(intf.frame_tick), 32'(e_tick));
        check("one_anode",  32'($countones(~intf.anode) <= 1), 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, rand_rec());
    endtask

    // Idle until the next edge will be a frame boundary.
    task automatic to_boundary();
        for (int i = 0; i < FRAME && (k % FRAME) != FRAME - 1; i++)
            step(1'b1, 1'b0, rand_rec());
    endtask

    // Idle until the first cycle of a frame.
    task automatic to_frame_start();
        for (int i = 0; i < FRAME && (k % FRAME) != 0; i++)
            step(1'b1, 1'b0, rand_rec());
    endtask

    initial begin
        seg_lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        k = 0;
`ifdef SEVENSEG_DIMMING_EN
        intf.brightness = 4'hF;
`endif

        // Reset held three cycles, then free-run without data.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, rand_rec());
        idle(2 * FRAME + 5);

        // Counting pattern, one load mid-frame.
        step(1'b1, 1'b1, mk(32'h76543210, 8'h00, 8'h00));
        idle(3 * FRAME);

        // Two loads in one frame: last one wins.
        to_frame_start();
        step(1'b1, 1'b1, mk(32'hAAAAAAAA, 8'h00, 8'h00));
        idle(5);
        step(1'b1, 1'b1, mk(32'h55555555, 8'h00, 8'h00));
        idle(2 * FRAME);

        // Upper four digits blanked, decimal point on digit 0 only.
        step(1'b1, 1'b1, mk(32'h89ABCDEF, 8'h01, 8'hF0));
        idle(2 * FRAME);

        // Load coincident with the boundary: applied directly, busy stays low.
        to_boundary();
        step(1'b1, 1'b1, mk(32'h0000000C, 8'hFF, 8'h00));
        idle(FRAME + 3);

        // Reset mid-frame with a load pending.
        idle(10);
        step(1'b1, 1'b1, mk(32'h12345678, 8'h00, 8'h00));
        idle(3);
        step(1'b0, 1'b0, rand_rec());
        step(1'b0, 1'b0, rand_rec());
        idle(FRAME + 2);

        // Random traffic.
        for (int i = 0; i < 1200; i++)
            step(1'b1, ($urandom_range(0, 24) == 0), rand_rec());

        // Random loads landing exactly on boundaries.
        for (int i = 0; i < 4; i++) begin
            to_boundary();
            step(1'b1, 1'b1, rand_rec());
            idle($urandom_range(1, 20));
        end
        idle(FRAME + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sevenseg_scan.md
# sevenseg_scan

Multiplexed 8-digit seven-segment display driver for the Nexys4 user-I/O path; it is the output-side counterpart to the pushbutton/switch input conditioning. It accepts hex digit values, decimal points and per-digit blanking through a load strobe. It double-buffers them so updates land only on frame boundaries, which prevents tearing. It time-multiplexes the common-anode display at a parameterized digit rate.

## Interface
- CLK_FREQUENCY_HZ, 100000000, input clock frequency
- DIGIT_FREQUENCY_HZ, 1000, per-digit dwell rate (frame rate = this / 8)
- CNTR_WIDTH, 32, dwell counter width
- SIMULATE, 0, 1 = use SIMULATE_FREQUENCY_CNT as dwell terminal count
- SIMULATE_FREQUENCY_CNT, 5, simulation terminal count

- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- digits_in  in  32  digit i = digits_in[4i+3:4i], hex value
- dp_in  in  8  decimal point per digit, 1 = lit
- blank_in  in  8  1 = digit dark
- load  in  1  single-cycle capture request for digits_in/dp_in/blank_in
- busy  out  1  loaded data pending, not yet displayed
- anode  out  8  digit enables, active-low, bit i = digit i
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- frame_tick  out  1  one-cycle pulse at each frame start

## Operation
- Dwell counter: top_cnt = SIMULATE ? SIMULATE_FREQUENCY_CNT : CLK_FREQUENCY_HZ/DIGIT_FREQUENCY_HZ − 1. Counts 0..top_cnt and wraps. Wrap = step.
- Digit index is 3 bits, 0..7. It advances on step. 7→0 is the frame boundary.
- Staging register holds {digits, dp, blank}. Display register holds the same fields.
- load with no boundary: staging ← inputs, busy ← 1. A load while busy overwrites staging; last load wins; busy stays 1.
- Boundary with busy=1 and no load: display ← staging, busy ← 0.
- load coincident with boundary: display and staging both ← inputs directly, busy ← 0.
- Output decode uses the display register and the current index:
  - blank[i]=1: anode all 1s, seg 7'h7F, dp 1.
  - Otherwise anode = ~(1<<i), dp = ~dp[i].
  - seg = hex pattern: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- Reset values:
  - Counter 0, index 0, busy 0, frame_tick 0.
  - Staging and display: digits 0, dp 0, blank 8'hFF.
  - anode 8'hFF, seg 7'h7F, dp 1.
- Reset mid-operation discards pending staging data. All outputs return to reset values on the next edge.

## Timing
- Dwell per digit = top_cnt+1 cycles. Frame = 8·(top_cnt+1) cycles.
- anode/seg/dp are registered. They reflect a new index or new display data 1 cycle after the index/display update.
- frame_tick is high for exactly the one cycle in which the index holds 0 after a 7→0 wrap. It is not asserted out of reset.
- busy rises the cycle after load. It falls the cycle after the applying boundary.
- Worst-case load-to-display latency is one frame + 1 cycle.
- No overlap: exactly one or zero anode bits low in any cycle.

## Configuration
- SEVENSEG_DIMMING_EN defined:
  - Adds input brightness [3:0] and a free-running 4-bit PWM counter, reset 0.
  - The anode of a non-blanked digit is driven low only while pwm_cnt ≤ brightness. Otherwise anode = 8'hFF.
  - seg/dp are unchanged by PWM. brightness 15 = full on.
  - Duty = (brightness+1)/16, sampled live (not staged).
- Undefined: no brightness port and no PWM counter. Anode is active for the full dwell.

## Test plan
All scenarios use SIMULATE=1, SIMULATE_FREQUENCY_CNT=5 (dwell 6, frame 48).
- Reset held 3 cycles, then released with no load:
  - During reset: anode FF, seg 7F, dp 1, busy 0.
  - After release: anode stays FF, frame_tick every 48 cycles.
  - Reasserting reset mid-frame with a load pending clears busy on the next edge.
- load 32'h76543210, dp 0, blank 0:
  - busy 1 until the boundary.
  - Then anode FE/seg 40 for 6 cycles, FD/79, …, 7F/78, repeating.
- Two loads in one frame, AAAAAAAA then 55555555 → only seg 12 appears afterward, never 08. busy stays 1 between the loads.
- blank_in F0, dp_in 01 → anodes for digits 4–7 never low. dp low only while anode = FE.
- load asserted on the boundary cycle → busy never rises. New digit-0 pattern appears 1 cycle later.
- SEVENSEG_DIMMING_EN with brightness 3 → each non-blanked anode is low 4 of every 16 cycles within its dwell. brightness 15 → low the full dwell.
